// File: rtl/int_sqrt_arb_pkg.sv
// Shared types for the integer square-root engine arbiter: FSM state encoding
// and the requester-ID width helper.
package int_sqrt_arb_pkg;

  typedef enum logic [1:0] {
    ENG_RST = 2'd0,
    IDLE    = 2'd1,
    LAUNCH  = 2'd2,
    WAIT    = 2'd3
  } state_t;

  // Never returns 0 so a two-requester build still gets a 1-bit ID.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps, so the
// first valid requester at or after ptr wins.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/int_sqrt_arbiter.sv
// Shares one external iterative square-root engine among NREQ requesters:
// round-robin grant, engine sequencing, watchdog abort, and a tagged response slot.
module int_sqrt_arbiter
  import int_sqrt_arb_pkg::*;
#(
  parameter int N       = 32,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64,
  parameter int IDW     = id_w(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0][N-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     resp_valid,
  output logic [N-1:0]             resp_data,
  output logic [IDW-1:0]           resp_id,
  output logic                     resp_err,
  input  logic                     resp_ready,
  output logic                     eng_rst,
  output logic                     eng_start,
  output logic [N-1:0]             eng_in,
  input  logic [N-1:0]             eng_out,
  input  logic                     eng_done,
  output logic                     busy
);

  localparam int CNT_W = $clog2(TIMEOUT);

  state_t           state, state_nxt;
  logic [IDW-1:0]   ptr;
  logic [N-1:0]     operand;
  logic [IDW-1:0]   tag;
  logic [CNT_W-1:0] cnt;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_idx;
  logic             grant_any;
  logic             slot_free;
  logic             cnt_full;
  logic             capture;
  logic             cap_err;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  assign slot_free = !resp_valid || resp_ready;
  assign cnt_full  = (cnt == CNT_W'(TIMEOUT - 1));
  assign eng_rst   = rst || (state == ENG_RST);
  assign eng_in    = operand;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ENG_RST;
    else     state <= state_nxt;
  end

  // A done engine with a full slot parks in WAIT; an abort likewise waits for the slot.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    eng_start = 1'b0;
    capture   = 1'b0;
    cap_err   = 1'b0;
    unique case (state)
      ENG_RST: state_nxt = IDLE;
      IDLE: begin
        if (grant_any) begin
          req_ready = grant;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        eng_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (slot_free && (eng_done || cnt_full)) begin
          capture   = 1'b1;
          cap_err   = !eng_done;
          state_nxt = ENG_RST;
        end
      end
      default: state_nxt = ENG_RST;
    endcase
    if (rst) begin
      req_ready = '0;
      eng_start = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= '0;
      operand <= '0;
      tag     <= '0;
      cnt     <= '0;
    end else begin
      if (state == IDLE && grant_any) begin
        operand <= req_data[grant_idx];
        tag     <= grant_idx;
        ptr     <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
      end
      // Count saturates at TIMEOUT-1 and freezes while a finished result is parked.
      if (state == ENG_RST)
        cnt <= '0;
      else if (state == WAIT && !eng_done && !cnt_full)
        cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
      resp_err   <= 1'b0;
    end else if (capture) begin
      resp_valid <= 1'b1;
      resp_data  <= cap_err ? '0 : eng_out;
      resp_id    <= tag;
      resp_err   <= cap_err;
    end else if (resp_valid && resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_int_sqrt_arbiter.sv
// Directed bench for int_sqrt_arbiter with a fixed-latency engine model that can be
// told to hang; responses and grants are logged each cycle and checked against constants.
module tb_int_sqrt_arbiter;

  localparam int N    = 32;
  localparam int NREQ = 4;
  localparam int LAT  = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0][N-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   resp_valid;
  logic [N-1:0]           resp_data;
  logic [1:0]             resp_id;
  logic                   resp_err;
  logic                   resp_ready;
  logic                   eng_rst;
  logic                   eng_start;
  logic [N-1:0]           eng_in;
  logic [N-1:0]           eng_out;
  logic                   eng_done;
  logic                   busy;

  int_sqrt_arbiter #(.N(N), .NREQ(NREQ), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_id(resp_id), .resp_err(resp_err), .resp_ready(resp_ready),
    .eng_rst(eng_rst), .eng_start(eng_start), .eng_in(eng_in),
    .eng_out(eng_out), .eng_done(eng_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- engine model ----------------
  logic         eng_busy = 1'b0;
  logic         hang = 1'b0;
  int           left = 0;
  logic [N-1:0] eng_lat_in = '0;

  function automatic logic [N-1:0] isqrt(input logic [N-1:0] x);
    logic [N-1:0] r;
    logic [N-1:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (32'd1 << b);
      if (64'(t) * 64'(t) <= 64'(x)) r = t;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (eng_rst) begin
      eng_busy <= 1'b0;
      eng_done <= 1'b0;
      eng_out  <= '0;
      left     <= 0;
    end else if (eng_start && !eng_busy && !eng_done) begin
      eng_busy   <= 1'b1;
      left       <= LAT - 1;
      eng_lat_in <= eng_in;
    end else if (eng_busy && !hang) begin
      if (left == 0) begin
        eng_busy <= 1'b0;
        eng_done <= 1'b1;
        eng_out  <= isqrt(eng_lat_in);
      end else begin
        left <= left - 1;
      end
    end
  end

  // ---------------- logging and checking ----------------
  typedef struct {
    int           id;
    logic [N-1:0] data;
    logic         err;
    int           cyc;
    logic         erst;
  } rsp_t;

  typedef struct {
    int port;
    int cyc;
  } gnt_t;

  typedef struct {
    int           port;
    logic [N-1:0] data;
    logic [N-1:0] root;
  } vec_t;

  rsp_t            rsp_q[$];
  gnt_t            grant_q[$];
  int              checks = 0;
  int              failures = 0;
  int              cyc = 0;
  int              n_start = 0;
  int              n_rst = 0;
  logic [NREQ-1:0] hold_mask = '0;
  logic            held = 1'b0;
  logic [N-1:0]    held_data = '0;
  logic [1:0]      held_id = '0;
  logic            held_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    logic [NREQ-1:0] acc;
    @(negedge clk);
    if (req_ready != '0) begin
      chk("grant_onehot_valid", $onehot(req_ready) && ((req_ready & ~req_valid) == '0), 1);
      for (int p = 0; p < NREQ; p++)
        if (req_ready[p]) grant_q.push_back('{port: p, cyc: cyc});
    end
    if (resp_valid && resp_ready)
      rsp_q.push_back('{id: int'(resp_id), data: resp_data, err: resp_err, cyc: cyc, erst: eng_rst});
    if (held && resp_valid)
      chk("resp_stable", {resp_err, resp_id, resp_data}, {held_err, held_id, held_data});
    held      = resp_valid && !resp_ready;
    held_data = resp_data;
    held_id   = resp_id;
    held_err  = resp_err;
    if (eng_start) n_start++;
    if (eng_rst) n_rst++;
    if (eng_busy) chk("eng_in_stable", eng_in, eng_lat_in);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~(acc & ~hold_mask);
    cyc++;
  endtask

  task automatic wait_rsp(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (rsp_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk({name, "_arrived"}, rsp_q.size() >= n, 1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 50) begin
      tick();
      k++;
    end
    chk("reach_idle", busy, 0);
  endtask

  task automatic pop_rsp(input string name, input int id, input logic [N-1:0] data,
                         input logic err);
    rsp_t r;
    chk({name, "_present"}, rsp_q.size() != 0, 1);
    if (rsp_q.size() != 0) begin
      r = rsp_q.pop_front();
      chk({name, "_id"}, r.id, id);
      chk({name, "_data"}, r.data, data);
      chk({name, "_err"}, r.err, err);
    end
  endtask

  task automatic submit(input int p, input logic [N-1:0] d);
    req_data[p]  = d;
    req_valid[p] = 1'b1;
  endtask

  vec_t vecs[8];

  initial begin
    int   g0;
    int   found;
    int   dt;
    rsp_t r;

    vecs[0] = '{port: 2, data: 32'd144,        root: 32'd12};
    vecs[1] = '{port: 0, data: 32'd0,          root: 32'd0};
    vecs[2] = '{port: 1, data: 32'd1,          root: 32'd1};
    vecs[3] = '{port: 0, data: 32'd15,         root: 32'd3};
    vecs[4] = '{port: 1, data: 32'd16,         root: 32'd4};
    vecs[5] = '{port: 2, data: 32'h4000_0000,  root: 32'd32768};
    vecs[6] = '{port: 0, data: 32'd99,         root: 32'd9};
    vecs[7] = '{port: 3, data: 32'hFFFF_FFFF,  root: 32'd65535};

    rst        = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    resp_ready = 1'b1;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_eng_rst", eng_rst, 1);
    chk("rst_busy", busy, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_eng_rst", eng_rst, 1);
    @(posedge clk);
    #1;
    tick();
    chk("idle_after_rst", busy, 0);

    // ---------------- single-request vectors ----------------
    foreach (vecs[i]) begin
      rsp_q.delete();
      grant_q.delete();
      n_start = 0;
      n_rst   = 0;
      submit(vecs[i].port, vecs[i].data);
      wait_rsp(1, 30, "vec");
      tick();
      tick();
      chk("vec_grants", grant_q.size(), 1);
      if (grant_q.size() != 0 && rsp_q.size() != 0) begin
        chk("vec_grant_port", grant_q[0].port, vecs[i].port);
        chk("vec_latency", rsp_q[0].cyc - grant_q[0].cyc, 6);
      end
      chk("vec_n_start", n_start, 1);
      chk("vec_n_rst", n_rst, 1);
      pop_rsp("vec", vecs[i].port, vecs[i].root, 1'b0);
    end

    // ---------------- contention, pointer at 0 ----------------
    rsp_q.delete();
    submit(0, 32'd16);
    submit(1, 32'd15);
    submit(2, 32'd0);
    submit(3, 32'hFFFF_FFFF);
    wait_rsp(4, 120, "cont");
    pop_rsp("cont0", 0, 32'd4, 1'b0);
    pop_rsp("cont1", 1, 32'd3, 1'b0);
    pop_rsp("cont2", 2, 32'd0, 1'b0);
    pop_rsp("cont3", 3, 32'd65535, 1'b0);
    wait_idle();

    // Pointer moves past the last winner: after 0,1 the search starts at 2.
    submit(0, 32'd81);
    submit(1, 32'd36);
    wait_rsp(2, 60, "rr01");
    pop_rsp("rr01_a", 0, 32'd9, 1'b0);
    pop_rsp("rr01_b", 1, 32'd6, 1'b0);
    wait_idle();
    submit(0, 32'd1000000);
    submit(3, 32'd50);
    wait_rsp(2, 60, "rr30");
    pop_rsp("rr30_a", 3, 32'd7, 1'b0);
    pop_rsp("rr30_b", 0, 32'd1000, 1'b0);
    wait_idle();

    // ---------------- back-pressure ----------------
    resp_ready = 1'b0;
    submit(1, 32'd49);
    submit(2, 32'd81);
    repeat (24) tick();
    chk("bp_no_handshake", rsp_q.size(), 0);
    chk("bp_valid", resp_valid, 1);
    chk("bp_id", resp_id, 1);
    chk("bp_data", resp_data, 7);
    chk("bp_parked_done", eng_done, 1);
    chk("bp_parked_busy", busy, 1);
    chk("bp_parked_no_rst", eng_rst, 0);
    resp_ready = 1'b1;
    wait_rsp(2, 20, "bp");
    pop_rsp("bp_first", 1, 32'd7, 1'b0);
    pop_rsp("bp_second", 2, 32'd9, 1'b0);
    wait_idle();

    // ---------------- watchdog ----------------
    hang = 1'b1;
    grant_q.delete();
    submit(0, 32'd25);
    wait_rsp(1, 40, "wd");
    if (grant_q.size() != 0 && rsp_q.size() != 0) begin
      dt = rsp_q[0].cyc - grant_q[0].cyc;
      chk("wd_latency", dt, 10);
      chk("wd_eng_rst_follows", rsp_q[0].erst, 1);
    end
    pop_rsp("wd", 0, 32'd0, 1'b1);
    hang = 1'b0;
    wait_idle();
    submit(1, 32'd36);
    wait_rsp(1, 30, "wd_next");
    pop_rsp("wd_next", 1, 32'd6, 1'b0);
    wait_idle();

    // ---------------- reset during WAIT ----------------
    resp_ready = 1'b0;
    submit(2, 32'd100);
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      tick();
      if (resp_valid) found = 1;
    end
    chk("mr_first_held", resp_valid, 1);
    submit(3, 32'd64);
    repeat (4) tick();
    chk("mr_in_wait_busy", eng_busy, 1);
    rst = 1'b1;
    #1;
    chk("mr_resp_valid", resp_valid, 0);
    chk("mr_resp_data", resp_data, 0);
    chk("mr_resp_id", resp_id, 0);
    chk("mr_req_ready", req_ready, 0);
    chk("mr_eng_start", eng_start, 0);
    chk("mr_eng_rst", eng_rst, 1);
    repeat (2) @(posedge clk);
    #1;
    rst        = 1'b0;
    resp_ready = 1'b1;
    req_valid  = '0;
    held       = 1'b0;
    rsp_q.delete();
    grant_q.delete();
    @(negedge clk);
    chk("mr_post_eng_rst", eng_rst, 1);
    @(posedge clk);
    #1;
    repeat (15) tick();
    chk("mr_no_stale_resp", rsp_q.size(), 0);
    chk("mr_no_grant", grant_q.size(), 0);

    // ---------------- fairness ----------------
    grant_q.delete();
    hold_mask = 4'b0001;
    submit(0, 32'd4);
    repeat (3) tick();
    g0 = grant_q.size();
    submit(3, 32'd9);
    found = -1;
    for (int k = 0; k < 60 && found < 0; k++) begin
      tick();
      for (int g = g0; g < grant_q.size(); g++)
        if (found < 0 && grant_q[g].port == 3) found = g - g0 + 1;
    end
    chk("fair_port3_granted", found > 0, 1);
    chk("fair_within_nreq", found <= NREQ, 1);
    hold_mask = '0;
    req_valid = '0;
    repeat (20) tick();
    chk("fair_resps", rsp_q.size() >= 2, 1);
    while (rsp_q.size() != 0) begin
      r = rsp_q.pop_front();
      chk("fair_rsp_data", r.data, (r.id == 3) ? 32'd3 : 32'd2);
      chk("fair_rsp_err", r.err, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/int_sqrt_arbiter.md
# int_sqrt_arbiter

Shares one iterative integer square-root engine among NREQ requesters. Requests arrive on per-requester valid/ready channels, are granted round-robin, sequenced through the engine (reset, start, wait for done), and returned on a single tagged response channel. A watchdog aborts a hung engine operation. The block sits between the client ports and the engine instance; the engine itself is external.

## Interface
- N, 32: operand/result width; must match the engine.
- NREQ, 4: number of requesters, ≥2.
- TIMEOUT, 64: maximum WAIT cycles before abort, ≥4.
- IDW, $clog2(NREQ): requester ID width (derived).

- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_data  in  NREQ×N  per-requester radicand.
- req_ready  out  NREQ  one-hot grant/accept; combinational.
- resp_valid  out  1  response valid.
- resp_data  out  N  floor(sqrt(radicand)); 0 on error.
- resp_id  out  IDW  requester index of the response.
- resp_err  out  1  1 = watchdog abort.
- resp_ready  in  1  response consumer ready.
- eng_rst  out  1  engine synchronous reset.
- eng_start  out  1  engine start pulse.
- eng_in  out  N  engine operand.
- eng_out  in  N  engine result; valid while eng_done is high.
- eng_done  in  1  engine done level; stays high until eng_rst.
- busy  out  1  high in any state other than IDLE.

## Operation
- Engine contract: eng_rst is sampled synchronously and returns the engine to idle. eng_start is sampled only in engine idle. eng_in must be stable from eng_start until eng_done. eng_done stays high until the next eng_rst, so every operation is followed by an eng_rst pulse.
- eng_rst = rst OR (state == ENG_RST). eng_in is always driven from the operand register.
- States:
  - ENG_RST: eng_rst=1 for one cycle, clear watchdog count → IDLE.
  - IDLE: if any req_valid, the round-robin winner w gets req_ready[w]=1 this cycle. Latch req_data[w] → operand and w → tag. Round-robin pointer ← (w+1) mod NREQ → LAUNCH. With no request, stay.
  - LAUNCH: eng_start=1 for one cycle → WAIT.
  - WAIT: watchdog count increments every cycle.
    - If eng_done and the response slot is free (!resp_valid or resp_ready): capture resp_data=eng_out, resp_id=tag, resp_err=0, resp_valid=1 → ENG_RST.
    - If eng_done and the slot is full: hold in WAIT; the count freezes and the engine holds its result.
    - If count reaches TIMEOUT-1 without eng_done and the slot is free: resp_data=0, resp_err=1 → ENG_RST. If the slot is full at that point, the abort waits in WAIT until the slot frees.
- Response slot: resp_valid is cleared when resp_valid && resp_ready, unless a new capture happens in the same cycle, in which case the register is overwritten and resp_valid stays 1. resp_data, resp_id and resp_err are stable while resp_valid && !resp_ready.
- Round robin: search starts at the pointer and wraps modulo NREQ. At most one requester is granted per operation.
- Reset (asynchronous): state=ENG_RST, pointer=0, resp_valid=0, resp_err=0, resp_data=0, resp_id=0, operand=0, count=0. During reset: req_ready=0, eng_start=0, eng_rst=1. A reset mid-operation drops the in-flight request without a response; the engine is re-reset on the first cycle after reset release.

## Timing
- Grant at cycle T (IDLE). eng_start at T+1. WAIT from T+2.
- eng_done first high at cycle D with a free slot: resp_valid high from D+1, eng_rst high at D+1, IDLE at D+2. Earliest next grant is D+2.
- Overhead per operation beyond engine latency: 4 cycles (grant, launch, capture, engine reset).
- A requester whose req_valid is high is granted within NREQ operations (starvation-free).
- Watchdog: with eng_done stuck low, the abort response appears TIMEOUT cycles after entering WAIT.

## Structure
- Package int_sqrt_arb_pkg: state enum {ENG_RST, IDLE, LAUNCH, WAIT} and the ID-width helper function.
- Sub-module rr_arbiter: purely combinational; inputs request vector and pointer, outputs one-hot grant and encoded index. Parameterised by NREQ.
- The top level holds the FSM, operand/tag registers, watchdog counter and response register.

## Test plan
- Single request: req 2, data 144 → grant only port 2; resp_data=12, resp_id=2, resp_err=0; engine sees one eng_start and one eng_rst pulse.
- Contention: all four ports valid with 16, 15, 0, 0xFFFFFFFF, pointer 0 → responses in ID order 0,1,2,3 with data 4, 3, 0, 65535. The next round starts at the port after the last winner.
- Back-pressure: resp_ready held low for 20 cycles across two requests → first response held stable; second operation parks in WAIT with eng_done high; no data lost; both responses delivered in order once resp_ready rises.
- Watchdog: engine model never asserts done, TIMEOUT=8 → resp_err=1, resp_data=0 after 8 WAIT cycles; eng_rst pulse follows; the next request completes normally.
- Mid-operation reset: assert rst during WAIT → outputs reach reset values immediately (async); no stale response after release; first post-reset cycle has eng_rst=1.
- Fairness: port 0 held valid continuously while port 3 pulses once → port 3 is granted within 4 operations.
